// File: rtl/mem_access_unit.sv
// mem_access_unit - load/store unit between the execute and write-back stages.
//
// Accepts one memory op from execute, performs it on a 64-bit request/grant
// data bus, aligns and sign/zero-extends load data, and returns a write-back
// for the destination register. Stalls upstream while an access is in flight.
//
// Optional feature macro: MISALIGN_SPLIT_EN
//   defined   - misaligned accesses are performed; those crossing an 8-byte
//               boundary are split into two bus beats (REQ2/WAIT2).
//   undefined - any misaligned access skips the bus and pulses misalign_err.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ex_valid            execute presents an op this cycle
//   load_code           LB/LH/LW/LD/LBU/LHU/LWU, 3'b111 = no load
//   store_code          SB/SH/SW/SD, 3'b111 = no store
//   mem_addr            effective address
//   store_data          rs2 value
//   rd_addr             load destination register
//   bus_req/we/addr     bus request, write flag, doubleword-aligned address
//   bus_wstrb/wdata     byte-lane enables and lane-shifted store data
//   bus_gnt             request accepted
//   bus_rvalid/rdata    read data return
//   lsu_stall           hold upstream stages
//   wb_valid/en/addr/data  write-back pulse, reg write enable, reg, value
//   misalign_err        misaligned-access pulse
module mem_access_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [2:0]            load_code,
    input  logic [2:0]            store_code,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [4:0]            rd_addr,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  lsu_stall,
    output logic                  wb_valid,
    output logic                  wb_en,
    output logic [4:0]            wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  misalign_err
);

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_REQ2, ST_WAIT2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
`endif

    state_t state, state_d;

    logic                is_load_q;
    logic [2:0]          code_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   sdata_q;
    logic [4:0]          rd_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                sel_load;
    logic [2:0]          code_in;
    logic [2:0]          szm1_in;
    logic                accept;
    logic [2:0]          off;
    logic [5:0]          sh;
    logic [7:0]          lane_mask;
    logic [ADDR_W-1:0]   base_addr;

    function automatic logic [2:0] size_m1(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [2:0] c, input logic [63:0] r);
        case (c)
            3'b000:  return {{56{r[7]}},  r[7:0]};
            3'b001:  return {{48{r[15]}}, r[15:0]};
            3'b010:  return {{32{r[31]}}, r[31:0]};
            3'b100:  return {56'd0, r[7:0]};
            3'b101:  return {48'd0, r[15:0]};
            3'b110:  return {32'd0, r[31:0]};
            default: return r;
        endcase
    endfunction

    // Load wins when both codes are valid.
    assign sel_load  = (load_code != 3'b111);
    assign code_in   = sel_load ? load_code : store_code;
    assign szm1_in   = size_m1(code_in[1:0]);
    assign accept    = rst_n && (state == ST_IDLE) && ex_valid &&
                       (sel_load || (store_code != 3'b111));

    assign off       = addr_q[2:0];
    assign sh        = {off, 3'b000};
    assign lane_mask = {{4{code_q[1] & code_q[0]}}, {2{code_q[1]}}, code_q[1] | code_q[0], 1'b1};
    assign base_addr = {addr_q[ADDR_W-1:3], 3'b000};

`ifdef MISALIGN_SPLIT_EN
    logic                split_q;
    logic                split_in;
    logic [15:0]         lanes_wide;
    logic [127:0]        wdata_wide;

    // Crosses the doubleword when offset + size - 1 runs past lane 7.
    assign split_in   = ({1'b0, mem_addr[2:0]} + {1'b0, szm1_in}) > 4'd7;
    assign lanes_wide = {8'h00, lane_mask} << off;
    assign wdata_wide = {64'd0, sdata_q} << sh;
`else
    logic                mis_q;
    logic                mis_in;

    assign mis_in = |(mem_addr[2:0] & szm1_in);
`endif

    always_comb begin
        state_d      = state;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = '0;
        bus_wstrb    = '0;
        bus_wdata    = '0;
        wb_valid     = 1'b0;
        wb_en        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        misalign_err = 1'b0;
        lsu_stall    = accept;

        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef MISALIGN_SPLIT_EN
                    state_d = ST_REQ;
`else
                    state_d = mis_in ? ST_DONE : ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                lsu_stall = 1'b1;
                bus_req   = 1'b1;
                bus_we    = ~is_load_q;
                bus_addr  = base_addr;
                if (!is_load_q) begin
`ifdef MISALIGN_SPLIT_EN
                    bus_wstrb = lanes_wide[7:0];
                    bus_wdata = wdata_wide[63:0];
`else
                    bus_wstrb = lane_mask << off;
                    bus_wdata = sdata_q << sh;
`endif
                end
                if (bus_gnt) begin
`ifdef MISALIGN_SPLIT_EN
                    state_d = is_load_q ? ST_WAIT : (split_q ? ST_REQ2 : ST_DONE);
`else
                    state_d = is_load_q ? ST_WAIT : ST_DONE;
`endif
                end
            end
            ST_WAIT: begin
                lsu_stall = 1'b1;
                if (bus_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
                    state_d = split_q ? ST_REQ2 : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_REQ2: begin
                lsu_stall = 1'b1;
                bus_req   = 1'b1;
                bus_we    = ~is_load_q;
                bus_addr  = base_addr + ADDR_W'(8);
                if (!is_load_q) begin
                    bus_wstrb = lanes_wide[15:8];
                    bus_wdata = wdata_wide[127:64];
                end
                if (bus_gnt) state_d = is_load_q ? ST_WAIT2 : ST_DONE;
            end
            ST_WAIT2: begin
                lsu_stall = 1'b1;
                if (bus_rvalid) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef MISALIGN_SPLIT_EN
                wb_valid = is_load_q;
`else
                wb_valid     = is_load_q & ~mis_q;
                misalign_err = mis_q;
`endif
                if (wb_valid) begin
                    wb_addr = rd_q;
                    wb_en   = |rd_q;
                    wb_data = extend(code_q, rdata_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_load_q <= 1'b0;
            code_q    <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q   <= 1'b0;
`else
            mis_q     <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (accept) begin
                is_load_q <= sel_load;
                code_q    <= code_in;
                addr_q    <= mem_addr;
                sdata_q   <= store_data;
                rd_q      <= rd_addr;
`ifdef MISALIGN_SPLIT_EN
                split_q   <= split_in;
`else
                mis_q     <= mis_in;
`endif
            end
            if (state == ST_WAIT && bus_rvalid)
                rdata_q <= bus_rdata >> sh;
`ifdef MISALIGN_SPLIT_EN
            // Beat 2 low lanes land just above the bytes taken from beat 1.
            if (state == ST_WAIT2 && bus_rvalid)
                rdata_q <= rdata_q | (bus_rdata << (7'd64 - {1'b0, sh}));
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  load_code;
    logic [2:0]  store_code;
    logic [63:0] mem_addr;
    logic [63:0] store_data;
    logic [4:0]  rd_addr;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [7:0]  bus_wstrb;
    logic [63:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        lsu_stall;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        misalign_err;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        en;
    } wb_t;

    wb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .load_code(load_code), .store_code(store_code),
        .mem_addr(mem_addr), .store_data(store_data), .rd_addr(rd_addr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .lsu_stall(lsu_stall), .wb_valid(wb_valid), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in the DONE cycle of a load: pops the scoreboard and compares.
    task automatic check_wb(input string tag);
        wb_t e;
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
        chk({tag, ".sb_pending"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".wb_addr"}, 64'(wb_addr), 64'(e.addr));
            chk({tag, ".wb_data"}, wb_data, e.data);
            chk({tag, ".wb_en"},   64'(wb_en),   64'(e.en));
        end
        chk({tag, ".stall_done"}, 64'(lsu_stall), 64'd0);
    endtask

    // Single-beat load: grant immediately, rvalid the cycle after the grant.
    task automatic load_op(input string tag, input logic [2:0] lc, input logic [2:0] sc,
                           input logic [63:0] a, input logic [4:0] rd,
                           input logic [63:0] rdata, input logic [63:0] exp_d);
        wb_t e;
        step();
        ex_valid = 1'b1; load_code = lc; store_code = sc; mem_addr = a;
        rd_addr = rd; store_data = 64'h5555_5555_5555_5555; bus_gnt = 1'b1;
        #1 chk({tag, ".stall_accept"}, 64'(lsu_stall), 64'd1);
        e.addr = rd; e.data = exp_d; e.en = (rd != 5'd0);
        sb.push_back(e);
        step();
        ex_valid = 1'b0; load_code = 3'b111; store_code = 3'b111;
        #1;
        chk({tag, ".bus_req"},   64'(bus_req),   64'd1);
        chk({tag, ".bus_addr"},  bus_addr,       {a[63:3], 3'b000});
        chk({tag, ".bus_we"},    64'(bus_we),    64'd0);
        chk({tag, ".bus_wstrb"}, 64'(bus_wstrb), 64'd0);
        step();
        bus_gnt = 1'b0;
        #1;
        chk({tag, ".req_drop"},  64'(bus_req),   64'd0);
        chk({tag, ".stall_wait"}, 64'(lsu_stall), 64'd1);
        chk({tag, ".no_early_wb"}, 64'(wb_valid), 64'd0);
        bus_rvalid = 1'b1; bus_rdata = rdata;
        step();
        bus_rvalid = 1'b0; bus_rdata = '0;
        #1 check_wb(tag);
    endtask

    // Store with grant held off for 'delay' cycles of REQ.
    task automatic store_op(input string tag, input logic [2:0] sc, input logic [63:0] a,
                            input logic [63:0] d, input int delay,
                            input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        step();
        ex_valid = 1'b1; load_code = 3'b111; store_code = sc; mem_addr = a;
        store_data = d; rd_addr = 5'd9; bus_gnt = 1'b0;
        #1 chk({tag, ".stall_accept"}, 64'(lsu_stall), 64'd1);
        step();
        ex_valid = 1'b0; store_code = 3'b111;
        for (int i = 0; i <= delay; i++) begin
            #1;
            chk({tag, ".bus_req"},   64'(bus_req),   64'd1);
            chk({tag, ".bus_we"},    64'(bus_we),    64'd1);
            chk({tag, ".bus_addr"},  bus_addr,       {a[63:3], 3'b000});
            chk({tag, ".bus_wstrb"}, 64'(bus_wstrb), 64'(exp_strb));
            chk({tag, ".bus_wdata"}, bus_wdata,      exp_wdata);
            chk({tag, ".stall_req"}, 64'(lsu_stall), 64'd1);
            chk({tag, ".no_wb"},     64'(wb_valid),  64'd0);
            if (i == delay) bus_gnt = 1'b1;
            step();
        end
        bus_gnt = 1'b0;
        #1;
        chk({tag, ".done_req"},   64'(bus_req),   64'd0);
        chk({tag, ".done_wb"},    64'(wb_valid),  64'd0);
        chk({tag, ".done_stall"}, 64'(lsu_stall), 64'd0);
        chk({tag, ".done_mis"},   64'(misalign_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; load_code = 3'b111; store_code = 3'b111;
        mem_addr = '0; store_data = '0; rd_addr = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) step();
        #1;
        chk("rst.bus_req",   64'(bus_req),   64'd0);
        chk("rst.bus_addr",  bus_addr,       64'd0);
        chk("rst.bus_wstrb", 64'(bus_wstrb), 64'd0);
        chk("rst.lsu_stall", 64'(lsu_stall), 64'd0);
        chk("rst.wb_valid",  64'(wb_valid),  64'd0);
        chk("rst.misalign",  64'(misalign_err), 64'd0);
        rst_n = 1'b1;

        load_op("lw", 3'b010, 3'b111, 64'h1004, 5'd5,
                64'h8000_0001_DEAD_BEEF, 64'hFFFF_FFFF_8000_0001);
        store_op("sb", 3'b000, 64'h2003, 64'hAB, 3, 8'h08, 64'hAB00_0000);
        load_op("lbu_r0", 3'b100, 3'b111, 64'h7, 5'd0,
                64'h9C11_2233_4455_6677, 64'h9C);
        load_op("lb", 3'b000, 3'b111, 64'h11, 5'd7,
                64'h0000_0000_0000_F200, 64'hFFFF_FFFF_FFFF_FFF2);
        load_op("lhu", 3'b101, 3'b111, 64'h26, 5'd8,
                64'hBEEF_0000_0000_0000, 64'hBEEF);
        load_op("ld", 3'b011, 3'b111, 64'h38, 5'd31,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        load_op("lw_and_sw", 3'b010, 3'b010, 64'h6008, 5'd12,
                64'h1234_5678_7FFF_FFFF, 64'h7FFF_FFFF);
        store_op("sd", 3'b011, 64'h6000, 64'h0123_4567_89AB_CDEF, 0,
                 8'hFF, 64'h0123_4567_89AB_CDEF);
        store_op("sh", 3'b001, 64'h7006, 64'hCAFE, 1, 8'hC0, 64'hCAFE_0000_0000_0000);

`ifdef MISALIGN_SPLIT_EN
        load_op("lh_mis", 3'b001, 3'b111, 64'h3001, 5'd4,
                64'h0000_0000_00FE_DC00, 64'hFFFF_FFFF_FFFF_FEDC);

        begin : split_ld
            wb_t e;
            step();
            ex_valid = 1'b1; load_code = 3'b011; store_code = 3'b111;
            mem_addr = 64'h4006; rd_addr = 5'd6; bus_gnt = 1'b1;
            e.addr = 5'd6; e.data = 64'h3344_5566_7788_1122; e.en = 1'b1;
            sb.push_back(e);
            step();
            ex_valid = 1'b0; load_code = 3'b111;
            #1 chk("split.beat1_addr", bus_addr, 64'h4000);
            chk("split.beat1_req", 64'(bus_req), 64'd1);
            step();
            bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h1122_0000_0000_0000;
            #1 chk("split.stall_w1", 64'(lsu_stall), 64'd1);
            step();
            bus_rvalid = 1'b0; bus_gnt = 1'b1;
            #1 chk("split.beat2_addr", bus_addr, 64'h4008);
            chk("split.beat2_req", 64'(bus_req), 64'd1);
            step();
            bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h0000_3344_5566_7788;
            #1 chk("split.stall_w2", 64'(lsu_stall), 64'd1);
            step();
            bus_rvalid = 1'b0;
            #1 check_wb("split");
            chk("split.no_mis", 64'(misalign_err), 64'd0);
        end
`else
        step();
        ex_valid = 1'b1; load_code = 3'b001; store_code = 3'b111;
        mem_addr = 64'h3001; rd_addr = 5'd4;
        #1 chk("mis.stall_accept", 64'(lsu_stall), 64'd1);
        step();
        ex_valid = 1'b0; load_code = 3'b111;
        #1;
        chk("mis.err",      64'(misalign_err), 64'd1);
        chk("mis.no_req",   64'(bus_req),      64'd0);
        chk("mis.no_wb",    64'(wb_valid),     64'd0);
        chk("mis.no_stall", 64'(lsu_stall),    64'd0);
        step();
        #1;
        chk("mis.err_pulse", 64'(misalign_err), 64'd0);
        chk("mis.no_req2",   64'(bus_req),      64'd0);

        step();
        ex_valid = 1'b1; store_code = 3'b010; mem_addr = 64'h4006; store_data = 64'h77;
        step();
        ex_valid = 1'b0; store_code = 3'b111;
        #1;
        chk("mis_sw.err",    64'(misalign_err), 64'd1);
        chk("mis_sw.no_req", 64'(bus_req),      64'd0);
`endif

        // Reset while waiting for read data; the late rvalid must be ignored.
        step();
        ex_valid = 1'b1; load_code = 3'b010; store_code = 3'b111;
        mem_addr = 64'h5000; rd_addr = 5'd3; bus_gnt = 1'b1;
        step();
        ex_valid = 1'b0; load_code = 3'b111;
        step();
        bus_gnt = 1'b0;
        #1 chk("rstw.in_wait", 64'(lsu_stall), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("rstw.bus_req",   64'(bus_req),   64'd0);
        chk("rstw.lsu_stall", 64'(lsu_stall), 64'd0);
        chk("rstw.wb_valid",  64'(wb_valid),  64'd0);
        step();
        bus_rvalid = 1'b0; bus_rdata = '0;
        #1;
        chk("rstw.late_wb",   64'(wb_valid),  64'd0);
        chk("rstw.wb_data",   wb_data,        64'd0);
        chk("rstw.misalign",  64'(misalign_err), 64'd0);
        chk("rstw.bus_addr",  bus_addr,       64'd0);
        step();
        #1 chk("rstw.still_idle", 64'(wb_valid | bus_req | lsu_stall), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
